// File: rtl/isp_pkg.sv
// Shared ISP stream definitions: colour codes, monitor error bits and
// the colour-expectation FSM encoding.
package isp_pkg;

  typedef enum logic [1:0] {
    RED   = 2'd0,
    GREEN = 2'd1,
    BLUE  = 2'd2,
    VOID  = 2'd3
  } color_e;

  localparam int ERR_ORDER    = 0;
  localparam int ERR_VOID     = 1;
  localparam int ERR_LAST_COL = 2;
  localparam int ERR_LAST_PIC = 3;
  localparam int ERR_OVERFLOW = 4;
  localparam int ERR_W        = 5;

  typedef enum logic [1:0] {
    EXP_R = 2'd0,
    EXP_G = 2'd1,
    EXP_B = 2'd2
  } exp_state_e;

  function automatic color_e exp_color(exp_state_e s);
    case (s)
      EXP_G:   return GREEN;
      EXP_B:   return BLUE;
      default: return RED;
    endcase
  endfunction

endpackage

// File: rtl/sat_acc.sv
// Saturating accumulator with synchronous clear. Exposes the post-add value
// so the owner can capture a final sum in the same cycle it clears.
module sat_acc #(
  parameter int W    = 14,
  parameter int IN_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            add,
  input  logic [IN_W-1:0] val,
  output logic [W-1:0]    sum_nxt
);

  logic [W-1:0] sum;
  logic [W:0]   raw;

  always_comb begin
    raw     = {1'b0, sum} + {{(W + 1 - IN_W){1'b0}}, val};
    sum_nxt = sum;
    if (add) sum_nxt = raw[W] ? '1 : raw[W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst || clr) sum <= '0;
    else            sum <= sum_nxt;
  end

endmodule

// File: rtl/rgb_stream_stats.sv
// In-line RGB stream monitor: 1-cycle pass-through, beat order and framing
// checks, and per-picture saturating channel sums for gray-world gains.
module rgb_stream_stats
  import isp_pkg::*;
#(
  parameter int  COLOR_DEPTH    = 8,
  parameter int  PIXELS_PER_COL = 16,
  parameter int  COLS_PER_PIC   = 2,
  parameter int  STRICT_ORDER   = 1,
  localparam int PIX_PER_PIC    = PIXELS_PER_COL * COLS_PER_PIC,
  localparam int CNT_W          = $clog2(PIX_PER_PIC + 1),
  localparam int SUM_W          = COLOR_DEPTH + CNT_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [COLOR_DEPTH-1:0] pixel_in,
  input  logic                   valid_in,
  input  logic [1:0]             color_in,
  input  logic                   last_col_in,
  input  logic                   last_pic_in,
  input  logic                   err_clr,
  output logic [COLOR_DEPTH-1:0] pixel_out,
  output logic                   valid_out,
  output logic [1:0]             color_out,
  output logic                   last_col_out,
  output logic                   last_pic_out,
  output logic [ERR_W-1:0]       err,
  output logic                   stats_valid,
  output logic [SUM_W-1:0]       sum_r,
  output logic [SUM_W-1:0]       sum_g,
  output logic [SUM_W-1:0]       sum_b,
  output logic [CNT_W-1:0]       pix_count
);

  localparam logic [CNT_W-1:0] IDX_MAX = CNT_W'(PIX_PER_PIC);

  color_e                  color;
  exp_state_e              state, state_nxt;
  logic [CNT_W-1:0]        idx, idx_nxt, cnt_sat;
  logic [ERR_W-1:0]        err_new;
  logic [2:0]              add;
  logic [2:0][SUM_W-1:0]   acc_nxt;
  logic                    pic_end, col_end, pic_last;

  assign color    = color_e'(color_in);
  assign col_end  = (int'(idx) % PIXELS_PER_COL) == PIXELS_PER_COL - 1;
  assign pic_last = idx == CNT_W'(PIX_PER_PIC - 1);
  assign cnt_sat  = (idx == IDX_MAX) ? IDX_MAX : idx + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) state <= EXP_R;
    else     state <= state_nxt;
  end

  // Any non-VOID colour re-anchors the expectation, so one bad beat
  // produces one ORDER flag rather than a cascade.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    err_new   = '0;
    add       = '0;
    pic_end   = 1'b0;
    if (valid_in) begin
      if (color == VOID)
        err_new[ERR_VOID] = 1'b1;
      else if (STRICT_ORDER != 0 && color != exp_color(state))
        err_new[ERR_ORDER] = 1'b1;
      case (color)
        RED:     begin add[0] = 1'b1; state_nxt = EXP_G; end
        GREEN:   begin add[1] = 1'b1; state_nxt = EXP_B; end
        BLUE:    begin add[2] = 1'b1; state_nxt = EXP_R; end
        default: ;
      endcase
      if (color == BLUE) begin
        err_new[ERR_LAST_COL] = last_col_in != col_end;
        err_new[ERR_LAST_PIC] = last_pic_in != pic_last;
        if (idx == IDX_MAX) err_new[ERR_OVERFLOW] = 1'b1;
        else                idx_nxt = idx + CNT_W'(1);
        if (last_pic_in) begin
          pic_end   = 1'b1;
          idx_nxt   = '0;
          state_nxt = EXP_R;
        end
      end else begin
        err_new[ERR_LAST_COL] = last_col_in;
        err_new[ERR_LAST_PIC] = last_pic_in;
      end
    end
  end

  for (genvar c = 0; c < 3; c++) begin : g_acc
    sat_acc #(.W(SUM_W), .IN_W(COLOR_DEPTH)) u_acc (
      .clk     (clk),
      .rst     (rst),
      .clr     (pic_end),
      .add     (add[c]),
      .val     (pixel_in),
      .sum_nxt (acc_nxt[c])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pixel_out    <= '0;
      valid_out    <= 1'b0;
      color_out    <= '0;
      last_col_out <= 1'b0;
      last_pic_out <= 1'b0;
      err          <= '0;
      stats_valid  <= 1'b0;
      sum_r        <= '0;
      sum_g        <= '0;
      sum_b        <= '0;
      pix_count    <= '0;
      idx          <= '0;
    end else begin
      pixel_out    <= pixel_in;
      valid_out    <= valid_in;
      color_out    <= color_in;
      last_col_out <= last_col_in;
      last_pic_out <= last_pic_in;
      idx          <= idx_nxt;
      // new errors win over a simultaneous clear
      err          <= (err_clr ? '0 : err) | err_new;
      stats_valid  <= pic_end;
      if (pic_end) begin
        sum_r     <= acc_nxt[0];
        sum_g     <= acc_nxt[1];
        sum_b     <= acc_nxt[2];
        pix_count <= cnt_sat;
      end
    end
  end

endmodule

// File: tb/tb_rgb_stream_stats.sv
// Randomised self-checking bench for rgb_stream_stats against a behavioural
// picture model; a second instance runs with relaxed colour ordering.
module tb_rgb_stream_stats;

  localparam int CD = 8, SW = 14, CW = 6, PPC = 16, PIX = 32;
  localparam int SMAX = (1 << SW) - 1;

  logic clk = 1'b0;
  logic rst, valid_in, last_col_in, last_pic_in, err_clr;
  logic [CD-1:0] pixel_in;
  logic [1:0]    color_in;

  logic [CD-1:0] pixel_out, l_pixel_out;
  logic          valid_out, l_valid_out, last_col_out, l_last_col_out;
  logic          last_pic_out, l_last_pic_out, stats_valid, l_stats_valid;
  logic [1:0]    color_out, l_color_out;
  logic [4:0]    err, l_err;
  logic [SW-1:0] sum_r, sum_g, sum_b, l_sum_r, l_sum_g, l_sum_b;
  logic [CW-1:0] pix_count, l_pix_count;

  rgb_stream_stats dut (
    .clk(clk), .rst(rst), .pixel_in(pixel_in), .valid_in(valid_in),
    .color_in(color_in), .last_col_in(last_col_in), .last_pic_in(last_pic_in),
    .err_clr(err_clr), .pixel_out(pixel_out), .valid_out(valid_out),
    .color_out(color_out), .last_col_out(last_col_out), .last_pic_out(last_pic_out),
    .err(err), .stats_valid(stats_valid), .sum_r(sum_r), .sum_g(sum_g),
    .sum_b(sum_b), .pix_count(pix_count)
  );

  rgb_stream_stats #(.STRICT_ORDER(0)) lax (
    .clk(clk), .rst(rst), .pixel_in(pixel_in), .valid_in(valid_in),
    .color_in(color_in), .last_col_in(last_col_in), .last_pic_in(last_pic_in),
    .err_clr(err_clr), .pixel_out(l_pixel_out), .valid_out(l_valid_out),
    .color_out(l_color_out), .last_col_out(l_last_col_out), .last_pic_out(l_last_pic_out),
    .err(l_err), .stats_valid(l_stats_valid), .sum_r(l_sum_r), .sum_g(l_sum_g),
    .sum_b(l_sum_b), .pix_count(l_pix_count)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int pt_bad = 0, sv_bad = 0, err_bad = 0, sv_cnt = 0, l_sv_cnt = 0;

  // picture model: running sums, pixel index, expected next colour
  int m_sum[3], m_h[3], m_hcnt, m_idx, m_exp;
  logic [4:0] m_err, m_err_lax;
  bit m_sv;

  task automatic model_step(input bit v, input int c, input int p,
                            input bit lc, input bit lp, input bit clr, input bit r);
    logic [4:0] nw;
    nw   = '0;
    m_sv = 1'b0;
    if (r) begin
      m_sum = '{0, 0, 0}; m_h = '{0, 0, 0}; m_hcnt = 0;
      m_idx = 0; m_exp = 0; m_err = '0; m_err_lax = '0;
      return;
    end
    if (v) begin
      if (c == 3) nw[1] = 1'b1;
      else begin
        if (c != m_exp) nw[0] = 1'b1;
        m_sum[c] = (m_sum[c] + p > SMAX) ? SMAX : m_sum[c] + p;
        m_exp = (c + 1) % 3;
      end
      if (c == 2) begin
        if (lc != (m_idx % PPC == PPC - 1)) nw[2] = 1'b1;
        if (lp != (m_idx == PIX - 1)) nw[3] = 1'b1;
        if (m_idx == PIX) nw[4] = 1'b1; else m_idx++;
        if (lp) begin
          m_h = m_sum; m_hcnt = m_idx; m_sv = 1'b1;
          m_sum = '{0, 0, 0}; m_idx = 0; m_exp = 0;
        end
      end else begin
        nw[2] = lc; nw[3] = lp;
      end
    end
    m_err     = (clr ? 5'd0 : m_err) | nw;
    m_err_lax = (clr ? 5'd0 : m_err_lax) | (nw & 5'b11110);
  endtask

  // one clock: drive at negedge, model at posedge, tally stream mismatches at next negedge
  task automatic beat(input bit v, input bit [1:0] c, input int p,
                      input bit lc = 0, input bit lp = 0, input bit clr = 0, input bit r = 0);
    logic [CD+4:0] exp_pt;
    valid_in = v; color_in = c; pixel_in = p[CD-1:0];
    last_col_in = lc; last_pic_in = lp; err_clr = clr; rst = r;
    @(posedge clk);
    model_step(v, int'(c), p, lc, lp, clr, r);
    @(negedge clk);
    exp_pt = r ? '0 : {p[CD-1:0], v, c, lc, lp};
    if ({pixel_out, valid_out, color_out, last_col_out, last_pic_out} !== exp_pt) pt_bad++;
    if ({l_pixel_out, l_valid_out, l_color_out, l_last_col_out, l_last_pic_out} !== exp_pt) pt_bad++;
    if (stats_valid !== m_sv || l_stats_valid !== m_sv) sv_bad++;
    if (err !== m_err || l_err !== m_err_lax) err_bad++;
    if (stats_valid) sv_cnt++;
    if (l_stats_valid) l_sv_cnt++;
  endtask

  task automatic idle(input int n);
    repeat (n) beat(1'b0, 2'($urandom), $urandom_range(0, 255), 1'($urandom), 1'($urandom));
  endtask

  task automatic send_pixel(input int r, input int g, input int b,
                            input bit lc, input bit lp, input int gap);
    beat(1'b1, 2'd0, r); idle(gap);
    beat(1'b1, 2'd1, g); idle(gap);
    beat(1'b1, 2'd2, b, lc, lp); idle(gap);
  endtask

  task automatic do_reset;
    beat(1'b1, 2'($urandom), $urandom_range(0, 255), 1'b1, 1'b1, 1'b0, 1'b1);
    idle(1);
  endtask

  task automatic test_reset;
    beat(1'b1, 2'd2, 200, 1'b1, 1'b1, 1'b1, 1'b1);
    beat(1'b1, 2'd3, 17, 1'b1, 1'b0, 1'b0, 1'b1);
    checks++; if ({pixel_out, valid_out, color_out, last_col_out, last_pic_out} !== '0) begin failures++; $display("FAIL reset_passthru got %h want 0", {pixel_out, valid_out, color_out, last_col_out, last_pic_out}); end
    checks++; if (err !== 5'd0) begin failures++; $display("FAIL reset_err got %b want 00000", err); end
    checks++; if (stats_valid !== 1'b0) begin failures++; $display("FAIL reset_stats_valid got %b want 0", stats_valid); end
    checks++; if ({sum_r, sum_g, sum_b, pix_count} !== '0) begin failures++; $display("FAIL reset_sums got %0d/%0d/%0d/%0d want 0", sum_r, sum_g, sum_b, pix_count); end
  endtask

  task automatic test_clean;
    int sv0, pt0;
    do_reset; sv0 = sv_cnt; pt0 = pt_bad;
    for (int k = 0; k < PIX; k++) send_pixel(10, 20, 30, k % PPC == PPC - 1, k == PIX - 1, 2);
    checks++; if (sv_cnt - sv0 != 1) begin failures++; $display("FAIL clean_stats_pulses got %0d want 1", sv_cnt - sv0); end
    checks++; if (sum_r !== 14'd320) begin failures++; $display("FAIL clean_sum_r got %0d want 320", sum_r); end
    checks++; if (sum_g !== 14'd640) begin failures++; $display("FAIL clean_sum_g got %0d want 640", sum_g); end
    checks++; if (sum_b !== 14'd960) begin failures++; $display("FAIL clean_sum_b got %0d want 960", sum_b); end
    checks++; if (pix_count !== 6'd32) begin failures++; $display("FAIL clean_pix_count got %0d want 32", pix_count); end
    checks++; if (err !== 5'd0) begin failures++; $display("FAIL clean_err got %b want 00000", err); end
    checks++; if (pt_bad != pt0) begin failures++; $display("FAIL clean_passthru got %0d bad cycles want 0", pt_bad - pt0); end
  endtask

  task automatic test_random_back_to_back;
    do_reset;
    for (int pic = 0; pic < 2; pic++) begin
      for (int k = 0; k < PIX; k++)
        send_pixel($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                   k % PPC == PPC - 1, k == PIX - 1, (k == PIX - 1) ? 0 : $urandom_range(0, 2));
      checks++; if ({sum_r, sum_g, sum_b} !== {SW'(m_h[0]), SW'(m_h[1]), SW'(m_h[2])}) begin failures++; $display("FAIL random_sums pic%0d got %0d/%0d/%0d want %0d/%0d/%0d", pic, sum_r, sum_g, sum_b, m_h[0], m_h[1], m_h[2]); end
      checks++; if (pix_count !== CW'(m_hcnt) || err !== 5'd0) begin failures++; $display("FAIL random_count_err pic%0d got %0d/%b want %0d/00000", pic, pix_count, err, m_hcnt); end
    end
  endtask

  task automatic test_order;
    int l0;
    do_reset; l0 = l_sv_cnt;
    beat(1'b1, 2'd1, 20); beat(1'b1, 2'd2, 30);
    checks++; if (err !== 5'b00001) begin failures++; $display("FAIL order_err got %b want 00001", err); end
    checks++; if (l_err !== 5'b00000) begin failures++; $display("FAIL order_lax_err got %b want 00000", l_err); end
    beat(1'b0, 2'd0, 0, 1'b0, 1'b0, 1'b1);
    beat(1'b1, 2'd0, 10);
    checks++; if (err !== 5'b00000) begin failures++; $display("FAIL order_resync got %b want 00000", err); end
    beat(1'b1, 2'd1, 20); beat(1'b1, 2'd2, 30);
    for (int k = 2; k < PIX; k++) send_pixel(10, 20, 30, k % PPC == PPC - 1, k == PIX - 1, 1);
    checks++; if ({sum_r, sum_g, sum_b} !== {14'd310, 14'd640, 14'd960}) begin failures++; $display("FAIL order_sums got %0d/%0d/%0d want 310/640/960", sum_r, sum_g, sum_b); end
    checks++; if ({l_sum_r, l_sum_g, l_sum_b, l_pix_count} !== {14'd310, 14'd640, 14'd960, 6'd32}) begin failures++; $display("FAIL order_lax_sums got %0d/%0d/%0d/%0d want 310/640/960/32", l_sum_r, l_sum_g, l_sum_b, l_pix_count); end
    checks++; if (l_sv_cnt - l0 != 1 || l_err !== 5'd0) begin failures++; $display("FAIL order_lax_pic got %0d pulses err %b want 1 00000", l_sv_cnt - l0, l_err); end
  endtask

  task automatic test_void;
    do_reset;
    beat(1'b1, 2'd0, 10); beat(1'b1, 2'd1, 20); beat(1'b1, 2'd3, 255);
    checks++; if (err !== 5'b00010) begin failures++; $display("FAIL void_err got %b want 00010", err); end
    beat(1'b1, 2'd2, 30);
    checks++; if (err !== 5'b00010) begin failures++; $display("FAIL void_then_b got %b want 00010", err); end
    for (int k = 1; k < PIX; k++) send_pixel(10, 20, 30, k % PPC == PPC - 1, k == PIX - 1, 0);
    checks++; if ({sum_r, sum_g, sum_b, pix_count} !== {14'd320, 14'd640, 14'd960, 6'd32}) begin failures++; $display("FAIL void_sums got %0d/%0d/%0d/%0d want 320/640/960/32", sum_r, sum_g, sum_b, pix_count); end
  endtask

  task automatic test_last_col;
    do_reset;
    for (int k = 0; k < PIX; k++)
      send_pixel(10, 20, 30, (k == 14) || (k % PPC == PPC - 1 && k != 15), k == PIX - 1, 0);
    checks++; if (err !== 5'b00100) begin failures++; $display("FAIL last_col_err got %b want 00100", err); end
    checks++; if (pix_count !== 6'd32) begin failures++; $display("FAIL last_col_count got %0d want 32", pix_count); end
  endtask

  task automatic test_last_pic;
    int sv0;
    do_reset; sv0 = sv_cnt;
    for (int k = 0; k < 34; k++) send_pixel(10, 20, 30, k < PIX && k % PPC == PPC - 1, k == 33, 0);
    checks++; if (err !== 5'b11000) begin failures++; $display("FAIL last_pic_err got %b want 11000", err); end
    checks++; if (pix_count !== 6'd32) begin failures++; $display("FAIL last_pic_count got %0d want 32", pix_count); end
    checks++; if (sv_cnt - sv0 != 1) begin failures++; $display("FAIL last_pic_pulses got %0d want 1", sv_cnt - sv0); end
    checks++; if (sum_b !== 14'd1020) begin failures++; $display("FAIL last_pic_sum_b got %0d want 1020", sum_b); end
  endtask

  task automatic test_saturate;
    do_reset;
    for (int k = 0; k < 71; k++) send_pixel(255, 255, 255, k % PPC == PPC - 1, k == 70, 0);
    checks++; if ({sum_r, sum_g, sum_b} !== {3{SW'(SMAX)}}) begin failures++; $display("FAIL saturate_sums got %0d/%0d/%0d want %0d", sum_r, sum_g, sum_b, SMAX); end
    checks++; if (err !== 5'b11100 || pix_count !== 6'd32) begin failures++; $display("FAIL saturate_err_count got %b/%0d want 11100/32", err, pix_count); end
  endtask

  task automatic test_rst_mid;
    int sv0;
    do_reset; sv0 = sv_cnt;
    for (int k = 0; k < 10; k++)
      send_pixel($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), 1'b0, 1'b0, 1);
    beat(1'b1, 2'd0, 99, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < PIX; k++) send_pixel(10, 20, 30, k % PPC == PPC - 1, k == PIX - 1, 1);
    checks++; if (sv_cnt - sv0 != 1) begin failures++; $display("FAIL rst_mid_pulses got %0d want 1", sv_cnt - sv0); end
    checks++; if ({sum_r, sum_g, sum_b, err} !== {14'd320, 14'd640, 14'd960, 5'd0}) begin failures++; $display("FAIL rst_mid_sums got %0d/%0d/%0d err %b want 320/640/960 00000", sum_r, sum_g, sum_b, err); end
  endtask

  task automatic test_clr_collision;
    do_reset;
    beat(1'b1, 2'd3, 255); beat(1'b1, 2'd1, 20);
    checks++; if (err !== 5'b00011) begin failures++; $display("FAIL clr_setup got %b want 00011", err); end
    beat(1'b1, 2'd3, 255, 1'b0, 1'b0, 1'b1);
    checks++; if (err !== 5'b00010) begin failures++; $display("FAIL clr_collision got %b want 00010", err); end
    beat(1'b0, 2'd0, 0, 1'b0, 1'b0, 1'b1);
    checks++; if (err !== 5'b00000) begin failures++; $display("FAIL clr_plain got %b want 00000", err); end
  endtask

  task automatic test_stream_integrity;
    checks++; if (pt_bad != 0) begin failures++; $display("FAIL passthru_cycles got %0d want 0", pt_bad); end
    checks++; if (sv_bad != 0) begin failures++; $display("FAIL stats_valid_cycles got %0d want 0", sv_bad); end
    checks++; if (err_bad != 0) begin failures++; $display("FAIL err_cycles got %0d want 0", err_bad); end
  endtask

  initial begin
    rst = 1'b1; valid_in = 1'b0; color_in = '0; pixel_in = '0;
    last_col_in = 1'b0; last_pic_in = 1'b0; err_clr = 1'b0;
    @(negedge clk);
    test_reset;
    test_clean;
    test_random_back_to_back;
    test_order;
    test_void;
    test_last_col;
    test_last_pic;
    test_saturate;
    test_rst_mid;
    test_clr_collision;
    test_stream_integrity;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rgb_stream_stats.md
# rgb_stream_stats

In-line monitor and statistics engine for the serialized RGB pixel stream from `denoise`, placed between denoise and white balance. It passes the stream through with one cycle of latency and checks the R→G→B beat order and the `last_col`/`last_pic` framing against the parametrised picture geometry. Per picture it accumulates saturating per-channel sums, which the white-balance block uses for gray-world gain computation. It generalises the fixed 4x8, 8-bit stream check used in simulation to any depth and geometry, and is synthesizable.

## Interface
- `COLOR_DEPTH`, 8, bits per beat.
- `PIXELS_PER_COL`, 16, RGB pixels between `last_col` marks.
- `COLS_PER_PIC`, 2, columns per picture; `PIX_PER_PIC = PIXELS_PER_COL*COLS_PER_PIC`.
- `STRICT_ORDER`, 1, 1 flags out-of-order colours; 0 accepts any order.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `pixel_in`  in  COLOR_DEPTH  beat value.
- `valid_in`  in  1  beat qualifier; idle gaps of any length allowed.
- `color_in`  in  2  0 R, 1 G, 2 B, 3 VOID.
- `last_col_in`, `last_pic_in`  in  1 each  framing marks, legal only on B beats.
- `err_clr`  in  1  clears sticky error flags.
- `pixel_out`, `valid_out`, `color_out`, `last_col_out`, `last_pic_out`  out  as inputs  registered pass-through.
- `err`  out  5  sticky flags: [0] ORDER, [1] VOID, [2] LAST_COL, [3] LAST_PIC, [4] OVERFLOW.
- `stats_valid`  out  1  one-cycle pulse at picture end.
- `sum_r`, `sum_g`, `sum_b`  out  SUM_W  channel sums, `SUM_W = COLOR_DEPTH + $clog2(PIX_PER_PIC+1)`.
- `pix_count`  out  $clog2(PIX_PER_PIC+1)  pixels in the last picture.

## Operation
- Expectation FSM states: EXP_R, EXP_G, EXP_B. Reset state is EXP_R. On a non-VOID beat, the next state is determined by `color_in` (R→EXP_G, G→EXP_B, B→EXP_R). This also resynchronises the FSM after an error.
- ORDER: set when `STRICT_ORDER=1` and `color_in` does not match the state.
- VOID beat: sets err[1]. The sums and the state are unchanged. The beat is still passed through.
- Accumulation: every R/G/B beat adds to its channel sum. Sums saturate at all-ones.
- Pixel index `idx` increments on each B beat and saturates at PIX_PER_PIC.
- LAST_COL: set when `last_col_in` is asserted on a non-B beat. Also set on a B beat where `last_col_in != (idx % PIXELS_PER_COL == PIXELS_PER_COL-1)`.
- LAST_PIC: set when `last_pic_in` is asserted on a non-B beat. Also set on a B beat where `last_pic_in != (idx == PIX_PER_PIC-1)`.
- OVERFLOW: set on a B beat when `idx == PIX_PER_PIC` already.
- Picture end (a B beat with `last_pic_in`), on the next cycle:
  - `stats_valid` pulses.
  - `sum_*` and `pix_count` (= idx+1, saturated) are loaded into held output registers.
  - Accumulators and idx clear. The FSM goes to EXP_R.
- Held outputs keep their values until the next `stats_valid`.
- Errors are sticky. `err_clr` clears them on the next edge. If a new error occurs in the same cycle as `err_clr`, the error wins and its bit stays set.

## Timing
- Pass-through latency is exactly 1 cycle. Outputs are bit-identical to the inputs, and `valid_out` is low during gaps.
- `err` bits update 1 cycle after the offending beat.
- `stats_valid` is asserted in the same cycle as `valid_out` for the final B beat. The new `sum_*` are visible in that cycle.
- A new picture's first beat may arrive in the cycle immediately after the final B beat. That beat accumulates into the cleared accumulators.
- Reset values:
  - All outputs are 0.
  - FSM in EXP_R; accumulators and idx are 0.
- `rst` mid-picture discards the partial picture and produces no `stats_valid`.

## Structure
- `isp_pkg` holds:
  - colour codes RED/GREEN/BLUE/VOID (shared with demosaic and denoise);
  - error bit indices;
  - FSM state encoding.
- Sub-module `sat_acc` (parametrised width, saturating add, synchronous clear) is instantiated three times.
- Target size is about 200 lines of RTL.

## Test plan
- **Clean picture:** defaults, 32 pixels with R=10, G=20, B=30, correct marks, and 2-cycle gaps between beats.
  - Expect one `stats_valid` with sum_r=320, sum_g=640, sum_b=960, pix_count=32, err=0.
  - Expect the pass-through to match the input delayed by 1 cycle.
- **Order error:** at pixel 0 send G then B, skipping R.
  - Expect err[0]=1 and sum_g+=G.
  - The following R beat is accepted without a new error.
  - With `STRICT_ORDER=0`, the same stimulus gives err=0.
- **VOID beat:** a VOID beat with value 0xFF between G and B.
  - Expect err[1]=1 and unchanged sums.
  - The B beat that follows is accepted in order.
- **Framing, `last_col`:** `last_col_in` on pixel 14's B beat and missing on pixel 15's B beat. Expect err[2]=1.
- **Framing, `last_pic`:** `last_pic_in` missing at pixel 31 and present at pixel 33. Expect err[4]=1, err[3]=1, pix_count=32 (saturated), and one `stats_valid`.
- **Reset and clear:**
  - `rst` after 10 pixels, then a clean picture: sums reflect only the clean picture.
  - `err_clr` in the same cycle as a new VOID error: err[1] remains 1.
